// File: rtl/s2mm_single_writer_if.sv
`default_nettype none
// ============================================================================
//  Module   : s2mm_single_writer_if
//  Brief    : Stream-in, sync_manager and AXI4 write-channel bundle for the
//             single-beat stream-to-memory writer.
//  Revision : 1.0  initial release
// ============================================================================
interface s2mm_single_writer_if #(
  parameter int MM_ADDR_WIDTH = 32,
  parameter int DATA_WIDTH    = 32
);
  // AXI4-Stream sample input
  logic [DATA_WIDTH-1:0]    S_AXIS_tdata;
  logic                     S_AXIS_tvalid;
  logic                     S_AXIS_tready;

  // sync_manager coupling
  logic [MM_ADDR_WIDTH-1:0] SM_write_buffer;
  logic                     SM_reading;
  logic                     SM_writing;

  // AXI4 write address channel
  logic [MM_ADDR_WIDTH-1:0] M_AXI_awaddr;
  logic [7:0]               M_AXI_awlen;
  logic [2:0]               M_AXI_awsize;
  logic [1:0]               M_AXI_awburst;
  logic [3:0]               M_AXI_awcache;
  logic [2:0]               M_AXI_awprot;
  logic                     M_AXI_awvalid;
  logic                     M_AXI_awready;

  // AXI4 write data channel
  logic [DATA_WIDTH-1:0]    M_AXI_wdata;
  logic [DATA_WIDTH/8-1:0]  M_AXI_wstrb;
  logic                     M_AXI_wlast;
  logic                     M_AXI_wvalid;
  logic                     M_AXI_wready;

  // AXI4 write response channel
  logic [1:0]               M_AXI_bresp;
  logic                     M_AXI_bvalid;
  logic                     M_AXI_bready;

  modport master (
    input  S_AXIS_tdata, S_AXIS_tvalid,
    output S_AXIS_tready,
    input  SM_write_buffer,
    output SM_reading, SM_writing,
    output M_AXI_awaddr, M_AXI_awlen, M_AXI_awsize, M_AXI_awburst,
    output M_AXI_awcache, M_AXI_awprot, M_AXI_awvalid,
    input  M_AXI_awready,
    output M_AXI_wdata, M_AXI_wstrb, M_AXI_wlast, M_AXI_wvalid,
    input  M_AXI_wready,
    input  M_AXI_bresp, M_AXI_bvalid,
    output M_AXI_bready
  );

  modport slave (
    output S_AXIS_tdata, S_AXIS_tvalid,
    input  S_AXIS_tready,
    output SM_write_buffer,
    input  SM_reading, SM_writing,
    input  M_AXI_awaddr, M_AXI_awlen, M_AXI_awsize, M_AXI_awburst,
    input  M_AXI_awcache, M_AXI_awprot, M_AXI_awvalid,
    output M_AXI_awready,
    input  M_AXI_wdata, M_AXI_wstrb, M_AXI_wlast, M_AXI_wvalid,
    output M_AXI_wready,
    output M_AXI_bresp, M_AXI_bvalid,
    input  M_AXI_bready
  );
endinterface
`default_nettype wire

// File: rtl/s2mm_single_writer.sv
`default_nettype none
// ============================================================================
//  Module   : s2mm_single_writer
//  Brief    : Takes one stream sample at a time and writes it as a single-beat
//             AXI4 write to the address supplied by sync_manager.
//  Revision : 1.0  initial release
// ============================================================================
module s2mm_single_writer #(
  parameter int MM_ADDR_WIDTH = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int ERR_WIDTH     = 16
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  input  logic                 enable,
  s2mm_single_writer_if.master bus,
  output logic [ERR_WIDTH-1:0] error_count
);

  localparam logic [1:0] c_idle = 2'd0;
  localparam logic [1:0] c_xfer = 2'd1;
  localparam logic [1:0] c_resp = 2'd2;

  localparam logic [2:0] c_awsize  = (DATA_WIDTH == 64) ? 3'd3 : 3'd2;
  localparam logic [1:0] c_awburst = 2'b01;
  localparam logic [3:0] c_awcache = 4'b0011;
  localparam logic [2:0] c_awprot  = 3'b000;

  logic [1:0]               r_state;
  logic [1:0]               w_state_next;
  logic                     r_awvalid;
  logic                     r_wvalid;
  logic [MM_ADDR_WIDTH-1:0] r_awaddr;
  logic [DATA_WIDTH-1:0]    r_wdata;
  logic [ERR_WIDTH-1:0]     r_error_count;

  logic w_tready;
  logic w_bready;
  logic w_accept;
  logic w_b_hs;
  logic w_aw_hs;
  logic w_w_hs;
  logic w_aw_done;
  logic w_w_done;

  // State register
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_state <= c_idle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic: XFER leaves on the cycle the later of AW/W completes
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      c_idle: begin
        if (w_accept) begin
          w_state_next = c_xfer;
        end
      end
      c_xfer: begin
        if (w_aw_done && w_w_done) begin
          w_state_next = c_resp;
        end
      end
      c_resp: begin
        if (bus.M_AXI_bvalid) begin
          w_state_next = c_idle;
        end
      end
      default: w_state_next = c_idle;
    endcase
  end

  // Output/handshake decode; aresetn gating keeps comb outputs quiet in reset
  always_comb begin
    w_tready  = aresetn && enable && (r_state == c_idle);
    w_bready  = aresetn && (r_state == c_resp);
    w_accept  = bus.S_AXIS_tvalid && w_tready;
    w_b_hs    = bus.M_AXI_bvalid && w_bready;
    w_aw_hs   = r_awvalid && bus.M_AXI_awready;
    w_w_hs    = r_wvalid && bus.M_AXI_wready;
    w_aw_done = !r_awvalid || bus.M_AXI_awready;
    w_w_done  = !r_wvalid || bus.M_AXI_wready;
  end

  // Channel valids and captured beat
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_awvalid <= 1'b0;
      r_wvalid  <= 1'b0;
      r_awaddr  <= '0;
      r_wdata   <= '0;
    end else if (w_accept) begin
      r_awvalid <= 1'b1;
      r_wvalid  <= 1'b1;
      r_awaddr  <= bus.SM_write_buffer;
      r_wdata   <= bus.S_AXIS_tdata;
    end else begin
      if (w_aw_hs) begin
        r_awvalid <= 1'b0;
      end
      if (w_w_hs) begin
        r_wvalid <= 1'b0;
      end
    end
  end

  // Saturating count of non-OKAY responses
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_error_count <= '0;
    end else if (w_b_hs && (bus.M_AXI_bresp != 2'b00) && !(&r_error_count)) begin
      r_error_count <= r_error_count + 1'b1;
    end
  end

  assign bus.S_AXIS_tready = w_tready;
  assign bus.SM_reading    = w_accept;
  assign bus.SM_writing    = w_b_hs;

  assign bus.M_AXI_awaddr  = r_awaddr;
  assign bus.M_AXI_awlen   = 8'd0;
  assign bus.M_AXI_awsize  = c_awsize;
  assign bus.M_AXI_awburst = c_awburst;
  assign bus.M_AXI_awcache = c_awcache;
  assign bus.M_AXI_awprot  = c_awprot;
  assign bus.M_AXI_awvalid = r_awvalid;

  assign bus.M_AXI_wdata   = r_wdata;
  assign bus.M_AXI_wstrb   = '1;
  assign bus.M_AXI_wlast   = 1'b1;
  assign bus.M_AXI_wvalid  = r_wvalid;

  assign bus.M_AXI_bready  = w_bready;

  assign error_count       = r_error_count;

endmodule
`default_nettype wire

// File: doc/s2mm_single_writer.md
# s2mm_single_writer

Stream-to-memory write master that sits directly upstream of `sync_manager`. It accepts samples from an AXI4-Stream source and writes each one as a single-beat AXI4 write to the address supplied on `SM_write_buffer`. It pulses `SM_reading` when a sample is taken, which advances the manager's fill offset. It pulses `SM_writing` when the write response arrives, which advances the manager's completion count and drives buffer rotation.

## Interface
Parameters:
- `MM_ADDR_WIDTH`, 32, AXI address width; matches `sync_manager`.
- `DATA_WIDTH`, 32, stream and memory data width in bits. Must be 32 or 64.
- `ERR_WIDTH`, 16, width of the error counter.

Ports:
- `aclk`  in  1  clock.
- `aresetn`  in  1  reset: synchronous, active-low.
- `enable`  in  1  when low, no new samples are accepted. A transfer already in flight completes.
- `S_AXIS_tdata`  in  DATA_WIDTH  sample.
- `S_AXIS_tvalid`  in  1  sample valid.
- `S_AXIS_tready`  out  1  sample accepted when high together with tvalid.
- `SM_write_buffer`  in  MM_ADDR_WIDTH  target address of the next sample, from `sync_manager`.
- `SM_reading`  out  1  one-cycle pulse per accepted sample.
- `SM_writing`  out  1  one-cycle pulse per completed write response.
- `M_AXI_awaddr`  out  MM_ADDR_WIDTH  write address.
- `M_AXI_awlen`  out  8  constant 0.
- `M_AXI_awsize`  out  3  constant log2(DATA_WIDTH/8).
- `M_AXI_awburst`  out  2  constant 2'b01 (INCR).
- `M_AXI_awcache`  out  4  constant 4'b0011.
- `M_AXI_awprot`  out  3  constant 3'b000.
- `M_AXI_awvalid`  out  1  address valid.
- `M_AXI_awready`  in  1  address ready.
- `M_AXI_wdata`  out  DATA_WIDTH  write data.
- `M_AXI_wstrb`  out  DATA_WIDTH/8  constant all ones.
- `M_AXI_wlast`  out  1  constant 1.
- `M_AXI_wvalid`  out  1  data valid.
- `M_AXI_wready`  in  1  data ready.
- `M_AXI_bresp`  in  2  write response.
- `M_AXI_bvalid`  in  1  response valid.
- `M_AXI_bready`  out  1  response ready.
- `error_count`  out  ERR_WIDTH  number of responses with bresp != 2'b00. Saturating.

## Operation
The block runs a three-state machine: IDLE, XFER, RESP.

- **IDLE**
  - `S_AXIS_tready` = `enable`.
  - On tvalid & tready, register tdata into `wdata_r` and `SM_write_buffer` into `awaddr_r`.
  - Set awvalid and wvalid, then go to XFER.
- **XFER**
  - awvalid is held until an awready handshake, then cleared.
  - wvalid is held until a wready handshake, then cleared. The two channels are independent; either may complete first, or both in the same cycle.
  - Go to RESP in the cycle when the last outstanding of the two handshakes occurs.
  - awaddr and wdata stay stable while their valid is high.
- **RESP**
  - bready = 1.
  - On bvalid, go to IDLE.
  - If bresp != 0, increment `error_count`, saturating at all ones.
  - The rotation count advances even on an error response.

Outputs:
- `SM_reading` = tvalid & tready, combinational. `sync_manager` samples it on the same edge as the capture, so the captured address is the pre-increment offset.
- `SM_writing` = bvalid & bready, combinational.

At most one transaction is outstanding, so write responses are strictly in order by construction.

Address handling:
- No address arithmetic is done here. `SM_write_buffer` already includes the buffer base and the word offset.
- The block does not check 4 KiB boundaries, because single beats cannot cross them.

## Timing
- Reset (aresetn low at a rising edge):
  - State returns to IDLE.
  - awvalid, wvalid, bready, tready, `SM_reading` and `SM_writing` are all 0.
  - `error_count` = 0.
  - `awaddr_r` and `wdata_r` = 0.
- Reset takes effect immediately, even mid-transfer. Valids drop without completing the handshake. The downstream interconnect must share the same reset.
- tready is 0 while the block is in XFER or RESP.
- Best case, with awready, wready and bvalid all responding with zero wait:
  - cycle 0: accept sample;
  - cycle 1: AW and W handshake;
  - cycle 2: B handshake;
  - cycle 3: next accept.
  - Sustained rate is therefore 1 sample per 3 cycles.
- Accept-to-valid latency: awvalid and wvalid go high on the cycle after the sample handshake.
- An `enable` deassertion while the block is in IDLE takes effect in the same cycle, via tready. An in-flight transfer always completes.
- If bvalid is already high on the first cycle of RESP, the B handshake happens that cycle.

## Test plan
- **Single sample.** Stimulus: `SM_write_buffer` = 0x1000_0040, tdata = 0xDEADBEEF, all ready signals high. Required response:
  - `SM_reading` pulses at cycle 0;
  - awaddr = 0x1000_0040 and wdata = 0xDEADBEEF at cycle 1;
  - `SM_writing` pulses at cycle 2;
  - tready is high again at cycle 3.
- **Skewed channels.** Stimulus: awready held low for 5 cycles, wready immediate. Required response: wvalid drops after 1 cycle; awvalid is held with a stable address; RESP is entered only after the AW handshake; exactly one `SM_writing` pulse.
- **Back-to-back stream.** Stimulus: 8 samples into the real `sync_manager` with SM_log_length = 2. Required response:
  - 8 writes at consecutive addresses (stride DATA_WIDTH/8) within buffer 3, then buffer 4;
  - exactly 8 `SM_reading` pulses and 8 `SM_writing` pulses.
- **Error response.** Stimulus: bresp = 2'b10 on the 2nd of 3 writes. Required response: `error_count` = 1; `SM_writing` still pulses 3 times. A separate run forces 2^16 + 1 errors and requires `error_count` to saturate at 0xFFFF.
- **Enable low.** Stimulus: `enable` dropped while the block is in XFER. Required response: the transfer completes with B; tready stays 0 afterwards; no further `SM_reading` pulses.
- **Mid-transfer reset.** Stimulus: aresetn low while awvalid is high. Required response: all valids are 0 on the next cycle; `error_count` = 0; the next sample after reset is captured correctly.
